qei_host_ctrl: RTL and testbench
================================

Name: qei_host_ctrl

Overview:
- Byte-wide command/response controller that sequences the quadrature-decoder position counter for an external host.
- Accepts opcodes over a valid/ready byte stream and snapshots the counter atomically.
- Serialises the snapshot LSB-first, and issues clear/preload strobes to the counter.
- Sits between the pin-level wrapper and the QEI counter core.

Parameters:
- CNT_W, 16, counter width; must be a multiple of 8; NB = CNT_W/8 bytes per transfer.
- RX_TIMEOUT, 255, idle cycles allowed between PRELOAD payload bytes before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  host byte valid
- cmd_ready  out  1  controller accepts byte
- cmd_data  in  8  opcode or payload byte
- rsp_valid  out  1  response byte valid
- rsp_ready  in  1  host accepts response byte
- rsp_data  out  8  response byte
- cnt_value  in  CNT_W  live counter value
- cnt_dir  in  1  live direction (1 = forward)
- cnt_clr  out  1  one-cycle clear strobe to counter
- cnt_load  out  1  one-cycle preload strobe
- cnt_load_val  out  CNT_W  preload value, valid with cnt_load
- busy  out  1  FSM not in IDLE
- err  out  1  sticky error flag
- index_in  in  1  encoder index (Z); ignored unless INDEX_HOME_EN

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: all outputs 0, cnt_load_val 0, FSM IDLE.
- A byte transfers on any edge where valid && ready. A response byte holds rsp_data stable until accepted.
- Opcodes: 0x01 READ, 0x02 CLEAR, 0x03 PRELOAD, 0x04 STATUS; 0x05 ARM_HOME only with the feature.
- Unknown opcode: sets err; byte is consumed; FSM stays IDLE.
- FSM states: IDLE, SEND, RX, APPLY.
- IDLE: cmd_ready=1, rsp_valid=0.
- READ: cnt_value is captured into snap on the accept edge, so the snapshot is atomic. FSM enters SEND with idx=0; rsp_valid=1 on the next cycle with snap[7:0]. Each rsp accept increments idx. After byte NB-1 is accepted, FSM returns to IDLE. cmd_ready=0 throughout SEND.
- STATUS: SEND of a single byte {cnt_dir, err, armed, 5'b0}. err clears on acceptance of this STATUS byte; a new error raised in the same cycle wins.
- CLEAR: cnt_clr=1 for exactly the one cycle after the accept edge; FSM stays IDLE.
- PRELOAD: FSM enters RX and collects NB payload bytes, LSB first; cmd_ready=1 in RX.
  - After the last byte, FSM enters APPLY for one cycle: cnt_load=1 and cnt_load_val = assembled value, then IDLE.
  - The timeout counter resets on each accepted byte. If it reaches RX_TIMEOUT: err=1, FSM returns to IDLE, no load.
- busy = (state != IDLE).
- cnt_clr and cnt_load are never asserted in the same cycle.
- rst mid-operation: FSM returns to IDLE; pending response and partial preload are discarded; no strobes issued.

Optional Feature:
- Macro: QEI_INDEX_HOME_EN.
- With the macro:
  - ARM_HOME sets armed=1.
  - index_in is 2-flop synchronised.
  - On the first synchronised rising edge while armed: cnt_clr pulses one cycle and armed clears.
  - If that edge coincides with APPLY: the load is applied; the clear is deferred one cycle.
  - rst clears armed.
- Without the macro: opcode 0x05 is unknown (sets err), armed reads 0, index_in is unused.

Decomposition:
- Package qei_pkg holds:
  - opcode localparams (OP_READ, OP_CLEAR, OP_PRELOAD, OP_STATUS, OP_ARM_HOME);
  - FSM state encoding;
  - STATUS bit positions.
- Sub-module qei_sync2: 2-flop synchroniser, also reusable by the wrapper for A/B inputs.

Test Plan:
- Reset: hold rst 4 cycles → all outputs 0, cmd_ready=1 the cycle after release.
- READ with cnt_value=0x1234, changed to 0xFFFF right after accept → rsp bytes 0x34 then 0x12; snapshot unaffected.
- READ with rsp_ready stalled 10 cycles per byte → rsp_data stable, rsp_valid held, cmd_ready=0 until the second byte is accepted.
- PRELOAD 0x03,0xCD,0xAB → single cnt_load pulse with cnt_load_val=0xABCD, no cnt_clr.
- PRELOAD 0x03,0x11 then idle 256 cycles → no cnt_load, err=1; STATUS → byte with bit6=1, then err=0.
- CLEAR → exactly one cnt_clr cycle. Unknown opcode 0x7E → err=1. With QEI_INDEX_HOME_EN: ARM_HOME plus an index pulse → one cnt_clr, armed=0.

Source files
------------

// File: rtl/qei_pkg.sv
// qei_pkg: opcodes, FSM state encoding and STATUS byte bit positions shared by
// qei_host_ctrl and its bench.
package qei_pkg;
    localparam logic [7:0] OP_READ     = 8'h01;
    localparam logic [7:0] OP_CLEAR    = 8'h02;
    localparam logic [7:0] OP_PRELOAD  = 8'h03;
    localparam logic [7:0] OP_STATUS   = 8'h04;
    localparam logic [7:0] OP_ARM_HOME = 8'h05;
    typedef enum logic [1:0] {S_IDLE, S_SEND, S_RX, S_APPLY} state_t;
    localparam int ST_DIR   = 7;
    localparam int ST_ERR   = 6;
    localparam int ST_ARMED = 5;
endpackage

// File: rtl/qei_host_ctrl_if.sv
// qei_host_ctrl_if: host command and response byte streams, both valid/ready.
interface qei_host_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    modport master (output cmd_valid, cmd_data, rsp_ready, input cmd_ready, rsp_valid, rsp_data);
    modport slave (input cmd_valid, cmd_data, rsp_ready, output cmd_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/qei_sync2.sv
// qei_sync2: two-flop synchroniser for asynchronous encoder pins (index, A/B).
module qei_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/qei_host_ctrl.sv
// qei_host_ctrl: byte command/response sequencer for the QEI position counter.
// Define QEI_INDEX_HOME_EN to add ARM_HOME (clear the counter on the next index edge).
module qei_host_ctrl
    import qei_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int RX_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    qei_host_ctrl_if.slave   bus,
    input  logic [CNT_W-1:0] cnt_value,
    input  logic             cnt_dir,
    output logic             cnt_clr,
    output logic             cnt_load,
    output logic [CNT_W-1:0] cnt_load_val,
    output logic             busy,
    output logic             err,
    input  logic             index_in
);
    localparam int NB = CNT_W / 8;
    localparam int IW = NB > 1 ? $clog2(NB) : 1;
    localparam int TW = $clog2(RX_TIMEOUT + 1);
    state_t state, state_n;
    logic [CNT_W-1:0] snap, rx_buf;
    logic [CNT_W+7:0] rx_sh;
    logic [IW-1:0] idx, last_idx;
    logic [TW-1:0] tmo;
    logic [7:0] stat;
    logic is_stat, clr_q, armed, home_clr;
    logic cmd_acc, rsp_acc, idle_acc, do_read, do_stat, do_clr, do_pre, do_arm, bad_op;
    logic rx_acc, rx_last, tmo_hit, tx_last;
    assign bus.cmd_ready = !rst && (state == S_IDLE || state == S_RX);
    assign bus.rsp_valid = !rst && state == S_SEND;
    assign bus.rsp_data  = snap[7:0];
    assign busy          = state != S_IDLE;
    assign cnt_load      = !rst && state == S_APPLY;
    assign cnt_clr       = !rst && clr_q;
    always_comb begin
        state_n  = state;
        cmd_acc  = bus.cmd_valid && bus.cmd_ready;
        rsp_acc  = bus.rsp_valid && bus.rsp_ready;
        idle_acc = cmd_acc && state == S_IDLE;
        do_read  = idle_acc && bus.cmd_data == OP_READ;
        do_stat  = idle_acc && bus.cmd_data == OP_STATUS;
        do_clr   = idle_acc && bus.cmd_data == OP_CLEAR;
        do_pre   = idle_acc && bus.cmd_data == OP_PRELOAD;
        bad_op   = idle_acc && !(do_read || do_stat || do_clr || do_pre || do_arm);
        rx_acc   = cmd_acc && state == S_RX;
        rx_last  = rx_acc && idx == IW'(NB - 1);
        tmo_hit  = state == S_RX && !cmd_acc && tmo == TW'(RX_TIMEOUT);
        tx_last  = rsp_acc && idx == last_idx;
        rx_sh    = {bus.cmd_data, rx_buf};
        stat     = '0;
        stat[ST_DIR]   = cnt_dir;
        stat[ST_ERR]   = err;
        stat[ST_ARMED] = armed;
        case (state)
            S_IDLE:  state_n = (do_read || do_stat) ? S_SEND : do_pre ? S_RX : S_IDLE;
            S_SEND:  state_n = tx_last ? S_IDLE : S_SEND;
            S_RX:    state_n = rx_last ? S_APPLY : tmo_hit ? S_IDLE : S_RX;
            default: state_n = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else state <= state_n;
    end
    // Responses shift out of snap LSB-first; payload bytes shift into rx_buf from the top.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap         <= '0;
            rx_buf       <= '0;
            cnt_load_val <= '0;
            idx          <= '0;
            last_idx     <= '0;
            tmo          <= '0;
            is_stat      <= 1'b0;
            err          <= 1'b0;
            clr_q        <= 1'b0;
        end else begin
            if (do_read || do_stat) begin
                snap     <= do_read ? cnt_value : CNT_W'(stat);
                last_idx <= do_read ? IW'(NB - 1) : '0;
                is_stat  <= do_stat;
            end else if (rsp_acc) begin
                snap <= snap >> 8;
            end
            if (rx_acc) rx_buf <= rx_sh[CNT_W+7:8];
            if (rx_last) cnt_load_val <= rx_sh[CNT_W+7:8];
            idx   <= (state_n != state) ? '0 : (rsp_acc || rx_acc) ? idx + 1'b1 : idx;
            tmo   <= (state == S_RX && !cmd_acc) ? tmo + 1'b1 : '0;
            err   <= (bad_op || tmo_hit) ? 1'b1 : (is_stat && tx_last) ? 1'b0 : err;
            clr_q <= do_clr || home_clr;
        end
    end
`ifdef QEI_INDEX_HOME_EN
    logic idx_s, idx_q, idx_rise, home_pend, home_fire;
    qei_sync2 #(.W(1)) u_index_sync (.clk(clk), .rst(rst), .d(index_in), .q(idx_s));
    assign do_arm    = idle_acc && bus.cmd_data == OP_ARM_HOME;
    assign idx_rise  = idx_s && !idx_q;
    assign home_fire = (armed && idx_rise) || home_pend;
    // A home clear that would land on the load cycle is held back one cycle.
    assign home_clr  = home_fire && state_n != S_APPLY;
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q     <= 1'b0;
            armed     <= 1'b0;
            home_pend <= 1'b0;
        end else begin
            idx_q     <= idx_s;
            armed     <= do_arm || (armed && !idx_rise);
            home_pend <= home_fire && state_n == S_APPLY;
        end
    end
`else
    logic unused_index;
    assign unused_index = index_in;
    assign do_arm       = 1'b0;
    assign armed        = 1'b0;
    assign home_clr     = 1'b0;
`endif
endmodule

// File: tb/tb_qei_host_ctrl.sv
// tb_qei_host_ctrl: scoreboard bench; expected response bytes are queued when a
// command is issued and compared when the host accepts each byte.
module tb_qei_host_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] cnt_value = '0;
    logic cnt_dir = 1'b0;
    logic index_in = 1'b0;
    logic cnt_clr, cnt_load, busy, err;
    logic [15:0] cnt_load_val;
    int errors = 0;
    int checks = 0;
    int clr_cnt = 0;
    int load_cnt = 0;
    int overlap_cnt = 0;
    logic [15:0] last_load = '0;
    logic [7:0] exp_q[$];

    qei_host_ctrl_if bus();

    qei_host_ctrl #(.CNT_W(16), .RX_TIMEOUT(255)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .cnt_value(cnt_value), .cnt_dir(cnt_dir),
        .cnt_clr(cnt_clr), .cnt_load(cnt_load), .cnt_load_val(cnt_load_val),
        .busy(busy), .err(err), .index_in(index_in)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            if (cnt_clr) clr_cnt++;
            if (cnt_load) begin
                load_cnt++;
                last_load = cnt_load_val;
            end
            if (cnt_clr && cnt_load) overlap_cnt++;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = b;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_%02h: cmd_ready=%b after %0d cycles, expected 1", b, bus.cmd_ready, n);
        end
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic recv_byte(input string name, input int stall, output int lat);
        logic [7:0] held, exp;
        lat = 0;
        @(negedge clk);
        while (!bus.rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: rsp_valid=%b after %0d cycles, expected 1", name, bus.rsp_valid, lat);
        end
        held = bus.rsp_data;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.rsp_valid, bus.rsp_data, bus.cmd_ready} !== {1'b1, held, 1'b0}) begin
                errors++;
                $display("FAIL %s_hold: valid/data/cmd_ready=%b/%02h/%b, expected 1/%02h/0",
                         name, bus.rsp_valid, bus.rsp_data, bus.cmd_ready, held);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        checks++;
        if (held !== exp) begin
            errors++;
            $display("FAIL %s_data: rsp_data=%02h, expected %02h", name, held, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.cmd_ready, bus.rsp_valid, bus.rsp_data, cnt_clr, cnt_load, cnt_load_val, busy, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%02h clr=%b load=%b val=%04h busy=%b err=%b, expected all 0",
                     bus.cmd_ready, bus.rsp_valid, bus.rsp_data, cnt_clr, cnt_load, cnt_load_val, busy, err);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.cmd_ready, busy} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: cmd_ready=%b busy=%b, expected 1 0", bus.cmd_ready, busy);
        end
    endtask

    task automatic test_read();
        int lat;
        cnt_value = 16'h1234;
        exp_q.push_back(8'h34);
        exp_q.push_back(8'h12);
        send_byte(8'h01);
        cnt_value = 16'hFFFF;
        recv_byte("read_b0", 0, lat);
        checks++;
        if (lat !== 0) begin
            errors++;
            $display("FAIL read_latency: first byte after %0d extra cycles, expected 0", lat);
        end
        recv_byte("read_b1", 0, lat);
        checks++;
        if ({busy, bus.cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL read_done: busy=%b cmd_ready=%b, expected 0 1", busy, bus.cmd_ready);
        end
    endtask

    task automatic test_read_stall();
        int lat;
        cnt_value = 16'hBEEF;
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        send_byte(8'h01);
        recv_byte("stall_b0", 10, lat);
        checks++;
        if ({busy, bus.cmd_ready} !== 2'b10) begin
            errors++;
            $display("FAIL stall_mid: busy=%b cmd_ready=%b, expected 1 0", busy, bus.cmd_ready);
        end
        recv_byte("stall_b1", 10, lat);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_done: cmd_ready=%b, expected 1", bus.cmd_ready);
        end
    endtask

    task automatic test_preload();
        int c0, l0;
        c0 = clr_cnt;
        l0 = load_cnt;
        send_byte(8'h03);
        send_byte(8'hCD);
        send_byte(8'hAB);
        @(negedge clk);
        checks++;
        if ({cnt_load, cnt_load_val, cnt_clr} !== {1'b1, 16'hABCD, 1'b0}) begin
            errors++;
            $display("FAIL preload_apply: load=%b val=%04h clr=%b, expected 1 abcd 0", cnt_load, cnt_load_val, cnt_clr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (load_cnt - l0 != 1 || clr_cnt - c0 != 0 || last_load !== 16'hABCD) begin
            errors++;
            $display("FAIL preload_count: loads=%0d clears=%0d val=%04h, expected 1 0 abcd",
                     load_cnt - l0, clr_cnt - c0, last_load);
        end
    endtask

    task automatic test_timeout_status();
        int l0, lat;
        l0 = load_cnt;
        send_byte(8'h03);
        send_byte(8'h11);
        repeat (200) @(negedge clk);
        checks++;
        if ({busy, err} !== 2'b10) begin
            errors++;
            $display("FAIL tmo_early: busy=%b err=%b, expected 1 0", busy, err);
        end
        repeat (60) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || err !== 1'b1 || load_cnt != l0) begin
            errors++;
            $display("FAIL tmo_abort: busy=%b err=%b loads=%0d, expected 0 1 0", busy, err, load_cnt - l0);
        end
        cnt_dir = 1'b1;
        exp_q.push_back(8'hC0);
        send_byte(8'h04);
        recv_byte("status_err", 0, lat);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL status_clear: err=%b, expected 0", err);
        end
    endtask

    task automatic test_clear();
        int c0;
        c0 = clr_cnt;
        send_byte(8'h02);
        @(negedge clk);
        checks++;
        if ({cnt_clr, cnt_load, busy} !== 3'b100) begin
            errors++;
            $display("FAIL clear_pulse: clr=%b load=%b busy=%b, expected 1 0 0", cnt_clr, cnt_load, busy);
        end
        @(negedge clk);
        checks++;
        if (cnt_clr !== 1'b0) begin
            errors++;
            $display("FAIL clear_width: clr=%b on second cycle, expected 0", cnt_clr);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (clr_cnt - c0 != 1) begin
            errors++;
            $display("FAIL clear_count: clears=%0d, expected 1", clr_cnt - c0);
        end
    endtask

    task automatic test_unknown();
        int lat;
        send_byte(8'h7E);
        @(negedge clk);
        checks++;
        if ({err, busy, bus.cmd_ready} !== 3'b101) begin
            errors++;
            $display("FAIL unknown_op: err=%b busy=%b cmd_ready=%b, expected 1 0 1", err, busy, bus.cmd_ready);
        end
        cnt_dir = 1'b0;
        exp_q.push_back(8'h40);
        send_byte(8'h04);
        recv_byte("status_unk", 0, lat);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL unknown_clear: err=%b, expected 0", err);
        end
    endtask

    task automatic test_arm_home();
        int lat, c0;
        send_byte(8'h05);
        @(negedge clk);
`ifdef QEI_INDEX_HOME_EN
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL arm_err: err=%b, expected 0", err);
        end
        exp_q.push_back(8'h20);
        send_byte(8'h04);
        recv_byte("status_armed", 0, lat);
        c0 = clr_cnt;
        index_in = 1'b1;
        repeat (3) @(negedge clk);
        index_in = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (clr_cnt - c0 != 1) begin
            errors++;
            $display("FAIL home_clear: clears=%0d, expected 1", clr_cnt - c0);
        end
        exp_q.push_back(8'h00);
        send_byte(8'h04);
        recv_byte("status_disarmed", 0, lat);
        index_in = 1'b1;
        repeat (3) @(negedge clk);
        index_in = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (clr_cnt - c0 != 1) begin
            errors++;
            $display("FAIL home_once: clears=%0d, expected 1", clr_cnt - c0);
        end
`else
        c0 = clr_cnt;
        checks++;
        if ({err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL arm_unknown: err=%b busy=%b, expected 1 0", err, busy);
        end
        index_in = 1'b1;
        repeat (3) @(negedge clk);
        index_in = 1'b0;
        exp_q.push_back(8'h40);
        send_byte(8'h04);
        recv_byte("status_noarm", 0, lat);
        checks++;
        if (err !== 1'b0 || clr_cnt != c0) begin
            errors++;
            $display("FAIL arm_noclear: err=%b clears=%0d, expected 0 0", err, clr_cnt - c0);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int c0, l0;
        c0 = clr_cnt;
        l0 = load_cnt;
        send_byte(8'h03);
        send_byte(8'h55);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || bus.cmd_ready !== 1'b1 || load_cnt != l0 || clr_cnt != c0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b rdy=%b loads=%0d clears=%0d, expected 0 1 0 0",
                     busy, bus.cmd_ready, load_cnt - l0, clr_cnt - c0);
        end
    endtask

    task automatic test_back_to_back();
        int lat, c0, l0;
        cnt_value = 16'h5A3C;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h5A);
        send_byte(8'h01);
        recv_byte("b2b_b0", 0, lat);
        recv_byte("b2b_b1", 0, lat);
        c0 = clr_cnt;
        l0 = load_cnt;
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h34);
        send_byte(8'h12);
        repeat (4) @(negedge clk);
        checks++;
        if (clr_cnt - c0 != 1 || load_cnt - l0 != 1 || last_load !== 16'h1234) begin
            errors++;
            $display("FAIL b2b_strobes: clears=%0d loads=%0d val=%04h, expected 1 1 1234",
                     clr_cnt - c0, load_cnt - l0, last_load);
        end
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL strobe_overlap: cycles with clr and load=%0d, expected 0", overlap_cnt);
        end
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_read();
        test_read_stall();
        test_preload();
        test_timeout_status();
        test_clear();
        test_unknown();
        test_arm_home();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
